// File: rtl/connect4_pkg.sv
// connect4_pkg: shared codes, board geometry and FSM states for the Connect-4 turn controller.
package connect4_pkg;
    localparam logic [1:0] GAME_INIT = 2'b00;
    localparam logic [1:0] P1_TURN   = 2'b01;
    localparam logic [1:0] P2_TURN   = 2'b10;
    localparam logic [1:0] END_GAME  = 2'b11;
    localparam logic [4:0] NO_CELL   = 5'b11111;
    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_P1    = 2'b01;
    localparam logic [1:0] WIN_P2    = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;
    localparam int BOARD_DIM = 4;
    typedef enum logic [2:0] {
        S_INIT, S_P1_WAIT, S_P1_COMMIT, S_P2_WAIT, S_P2_COMMIT, S_CHECK, S_END
    } fsm_t;
endpackage

// File: rtl/connect4_win_check.sv
// connect4_win_check: flags four-in-line (rows, columns, diagonals) for one player; cell = row*4 + col.
module connect4_win_check
    import connect4_pkg::*;
(
    input  logic [15:0] occ,
    input  logic [15:0] own,
    input  logic        player,
    output logic        win
);
    logic [15:0] mine;
    logic [9:0]  line;
    assign mine = occ & (player ? own : ~own);
    for (genvar r = 0; r < BOARD_DIM; r++) begin : g_line
        assign line[r]     = &mine[4*r +: 4];
        assign line[4 + r] = mine[r] & mine[4 + r] & mine[8 + r] & mine[12 + r];
    end
    assign line[8] = mine[0] & mine[5] & mine[10] & mine[15];
    assign line[9] = mine[3] & mine[6] & mine[9] & mine[12];
    assign win = |line;
endmodule

// File: rtl/connect4_turn_controller.sv
// connect4_turn_controller: sequences a 4x4 Connect-4 game, applies gravity and turn rules,
// auto-plays on timeout and detects win/draw.
module connect4_turn_controller
    import connect4_pkg::*;
#(
    parameter int TURN_TIMEOUT = 1000,
    parameter int TIMER_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       p1_req,
    input  logic [1:0] p1_col,
    input  logic       p2_req,
    input  logic [1:0] p2_col,
    output logic [1:0] state,
    output logic [4:0] column_position,
    output logic [1:0] winner,
    output logic       move_err,
    output logic [4:0] move_count
);
    fsm_t               fsm;
    logic [2:0]         heights [BOARD_DIM];
    logic [15:0]        occ, own;
    logic [TIMER_W-1:0] timer;
    logic               mover, win, is_p2, req, legal, timeout, take;
    logic [1:0]         req_col, auto_col, sel_col;

    assign is_p2    = fsm == S_P2_WAIT;
    assign req      = is_p2 ? p2_req : p1_req;
    assign req_col  = is_p2 ? p2_col : p1_col;
    assign legal    = req && heights[req_col] != 3'd4;
    assign timeout  = TURN_TIMEOUT != 0 && timer == TIMER_W'(TURN_TIMEOUT - 1);
    assign auto_col = heights[0] != 3'd4 ? 2'd0 :
                      heights[1] != 3'd4 ? 2'd1 :
                      heights[2] != 3'd4 ? 2'd2 : 2'd3;
    assign sel_col  = legal ? req_col : auto_col;
    assign take     = legal || timeout;

    connect4_win_check u_win (.occ(occ), .own(own), .player(mover), .win(win));

    // During COMMIT the registered cell index doubles as the latched move: [1:0]=col, [3:0]=cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm             <= S_END;
            state           <= END_GAME;
            column_position <= NO_CELL;
            winner          <= WIN_NONE;
            move_err        <= 1'b0;
            move_count      <= 5'd0;
            heights         <= '{default: '0};
            occ             <= 16'd0;
            own             <= 16'd0;
            timer           <= '0;
            mover           <= 1'b0;
        end else begin
            move_err        <= 1'b0;
            column_position <= NO_CELL;
            if (new_game) begin
                fsm   <= S_INIT;
                state <= GAME_INIT;
            end else begin
                case (fsm)
                    S_INIT: begin
                        heights    <= '{default: '0};
                        occ        <= 16'd0;
                        own        <= 16'd0;
                        move_count <= 5'd0;
                        winner     <= WIN_NONE;
                        timer      <= '0;
                        fsm        <= S_P1_WAIT;
                        state      <= P1_TURN;
                    end
                    S_P1_WAIT, S_P2_WAIT: begin
                        timer    <= timer + TIMER_W'(1);
                        move_err <= req && !legal;
                        if (take) begin
                            column_position <= {1'b0, heights[sel_col][1:0], sel_col};
                            fsm             <= is_p2 ? S_P2_COMMIT : S_P1_COMMIT;
                        end
                    end
                    S_P1_COMMIT, S_P2_COMMIT: begin
                        heights[column_position[1:0]] <= heights[column_position[1:0]] + 3'd1;
                        occ[column_position[3:0]]     <= 1'b1;
                        own[column_position[3:0]]     <= fsm == S_P2_COMMIT;
                        mover                         <= fsm == S_P2_COMMIT;
                        move_count                    <= move_count + 5'd1;
                        timer                         <= '0;
                        fsm                           <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (win) begin
                            winner <= mover ? WIN_P2 : WIN_P1;
                            fsm    <= S_END;
                            state  <= END_GAME;
                        end else if (move_count == 5'd16) begin
                            winner <= WIN_DRAW;
                            fsm    <= S_END;
                            state  <= END_GAME;
                        end else begin
                            fsm   <= mover ? S_P1_WAIT : S_P2_WAIT;
                            state <= mover ? P1_TURN : P2_TURN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
